// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the tick_stopwatch block:
//   state_e       - stopwatch control states (IDLE, RUN, PAUSE)
//   DIGIT_W       - width of one BCD display digit
//   ONES_MAX      - largest value of a "ones" digit (seconds/minutes ones)
//   TENS_MAX      - largest value of a "tens" digit (seconds/minutes tens)
//   digits_t      - the four display digits packed as MM:SS
//   subCntWidth() - prescaler width for a given ticks-per-second setting
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;

  typedef struct packed {
    logic [DIGIT_W-1:0] minTens;
    logic [DIGIT_W-1:0] minOnes;
    logic [DIGIT_W-1:0] secTens;
    logic [DIGIT_W-1:0] secOnes;
  } digits_t;

  // A single tick per second still needs a one-bit counter so the
  // prescaler compare stays well formed.
  function automatic int subCntWidth(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/tick_stopwatch_bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One mod-(MAX_VAL+1) BCD counter stage. Stages are chained by feeding one
// stage's carry_o into the next stage's en_i, so a full carry ripples
// through all stages in the same cycle.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   clr_i   - synchronous clear to zero (wins over en_i)
//   en_i    - advance by one this cycle
//   value_o - current digit value
//   carry_o - high when this stage wraps to zero on this cycle's edge
// ---------------------------------------------------------------------------
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX_VAL = ONES_MAX
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [DIGIT_W-1:0] value_o,
  output logic               carry_o
);

  logic [DIGIT_W-1:0] value_q;

  // Digit register: clear beats enable, and the digit wraps at MAX_VAL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else if (clr_i) begin
      value_q <= '0;
    end else if (en_i) begin
      value_q <= (value_q == MAX_VAL) ? '0 : value_q + 4'd1;
    end
  end

  // Carry is combinational so the next stage advances on the same edge.
  assign carry_o = en_i && !clr_i && (value_q == MAX_VAL);
  assign value_o = value_q;

endmodule

// File: rtl/tick_stopwatch.sv
// ---------------------------------------------------------------------------
// tick_stopwatch
// MM:SS stopwatch counting seconds derived from rising edges of a slow
// divided clock that lives in the clk_in domain.
// Parameter:
//   TICKS_PER_SEC - divided_clk rising edges per counted second (1..1023)
// Ports:
//   clk_in      - sole clock
//   rst         - synchronous active-high reset
//   divided_clk - slow square wave from the clock divider
//   start       - one-cycle run request
//   stop        - one-cycle pause request
//   clear       - one-cycle zero-and-idle request
//   lap         - one-cycle display freeze/release (lap build only)
//   tick        - registered one-cycle pulse per divided_clk rising edge
//   running     - high only while in RUN
//   min_tens, min_ones, sec_tens, sec_ones - BCD display digits
//   rollover    - one-cycle pulse when the count wraps 59:59 -> 00:00
// Configuration macro:
//   STOPWATCH_LAP_EN - adds the lap freeze flag and display latch; when
//                      undefined, lap is ignored and digits show the live
//                      count.
// ---------------------------------------------------------------------------
module tick_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 20
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               divided_clk,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               lap,
  output logic               tick,
  output logic               running,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               rollover
);

  localparam int               SUB_W    = subCntWidth(TICKS_PER_SEC);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  logic             prev_q;
  logic             tick_q;
  state_e           state_q;
  logic             running_q;
  logic [SUB_W-1:0] sub_cnt_q;
  logic [SUB_W-1:0] sub_cnt_d;
  logic             rollover_q;

  logic    countEn;
  logic    secAdv;
  logic    carrySecOnes;
  logic    carrySecTens;
  logic    carryMinOnes;
  logic    carryMinTens;
  digits_t liveDigits;
  digits_t shownDigits;

  // Rising-edge detector on divided_clk. prev_q comes out of reset high so
  // a divided_clk that is already high never produces a spurious tick.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      prev_q <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      prev_q <= divided_clk;
      tick_q <= divided_clk && !prev_q;
    end
  end

  // Control FSM with running registered alongside the state so it is
  // exactly "state is RUN". Clear beats stop, stop beats start.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else if (clear) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (stop) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        IDLE, PAUSE: begin
          if (start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // A tick only counts while RUN is held through the cycle; a coincident
  // stop or clear throws it away.
  assign countEn = (state_q == RUN) && tick_q && !clear && !stop;
  assign secAdv  = countEn && (sub_cnt_q == SUB_LAST);

  // Prescaler next state: wraps on the tick that advances seconds.
  always_comb begin
    sub_cnt_d = sub_cnt_q;
    if (clear) begin
      sub_cnt_d = '0;
    end else if (countEn) begin
      sub_cnt_d = secAdv ? '0 : sub_cnt_q + SUB_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sub_cnt_q <= '0;
    end else begin
      sub_cnt_q <= sub_cnt_d;
    end
  end

  bcd_digit #(.MAX_VAL(ONES_MAX)) uSecOnes (
    .clk_i(clk_in), .rst_i(rst), .clr_i(clear), .en_i(secAdv),
    .value_o(liveDigits.secOnes), .carry_o(carrySecOnes)
  );

  bcd_digit #(.MAX_VAL(TENS_MAX)) uSecTens (
    .clk_i(clk_in), .rst_i(rst), .clr_i(clear), .en_i(carrySecOnes),
    .value_o(liveDigits.secTens), .carry_o(carrySecTens)
  );

  bcd_digit #(.MAX_VAL(ONES_MAX)) uMinOnes (
    .clk_i(clk_in), .rst_i(rst), .clr_i(clear), .en_i(carrySecTens),
    .value_o(liveDigits.minOnes), .carry_o(carryMinOnes)
  );

  bcd_digit #(.MAX_VAL(TENS_MAX)) uMinTens (
    .clk_i(clk_in), .rst_i(rst), .clr_i(clear), .en_i(carryMinOnes),
    .value_o(liveDigits.minTens), .carry_o(carryMinTens)
  );

  // The top digit's carry is the 59:59 -> 00:00 wrap; registering it lines
  // the pulse up with the cycle the digits read 00:00.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rollover_q <= 1'b0;
    end else begin
      rollover_q <= carryMinTens;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic    freeze_q;
  digits_t lap_q;

  // Lap toggles the freeze flag only in RUN; the latch captures the digits
  // on display at the freezing lap while the live count keeps going.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      freeze_q <= 1'b0;
      lap_q    <= '0;
    end else if (clear) begin
      freeze_q <= 1'b0;
    end else if (lap && (state_q == RUN)) begin
      freeze_q <= !freeze_q;
      if (!freeze_q) begin
        lap_q <= liveDigits;
      end
    end
  end

  assign shownDigits = freeze_q ? lap_q : liveDigits;
`else
  logic unused_lap;

  assign unused_lap  = lap;
  assign shownDigits = liveDigits;
`endif

  assign tick     = tick_q;
  assign running  = running_q;
  assign rollover = rollover_q;
  assign min_tens = shownDigits.minTens;
  assign min_ones = shownDigits.minOnes;
  assign sec_tens = shownDigits.secTens;
  assign sec_ones = shownDigits.secOnes;

endmodule

// File: tb/tb_tick_stopwatch.sv
// ---------------------------------------------------------------------------
// tb_tick_stopwatch
// Drives tick_stopwatch (TICKS_PER_SEC = 2) through directed scenarios and a
// randomized phase. A reference model keeps elapsed time as a plain integer
// second count plus a sub-second tick count; each cycle's expected outputs
// are queued and a monitor compares them against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_tick_stopwatch;

  localparam int TPS = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  typedef struct packed {
    logic        tick;
    logic        running;
    logic [15:0] digits;
    logic        rollover;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       divided_clk = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       tick;
  logic       running;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       rollover;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   rollCount = 0;
  bit   dLvl = 1'b0;

  // Reference model state, in stopwatch terms rather than register terms.
  bit   mReady = 1'b0;
  bit   mPrev = 1'b1;
  bit   mTick = 1'b0;
  int   mMode = M_IDLE;
  int   mSub = 0;
  int   mSecs = 0;
  bit   mRoll = 1'b0;
  bit   mFreeze = 1'b0;
  int   mLatch = 0;

  tick_stopwatch #(.TICKS_PER_SEC(TPS)) dut (
    .clk_in(clk_in), .rst(rst), .divided_clk(divided_clk),
    .start(start), .stop(stop), .clear(clear), .lap(lap),
    .tick(tick), .running(running),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .rollover(rollover)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] toDigits(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dutDigits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic checkField(input string name, input logic [15:0] act,
                            input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model: what the stopwatch should look like after
  // the edge, given the inputs held during the cycle.
  task automatic stepModel(input bit r, input bit d, input bit s, input bit p,
                           input bit c, input bit l);
    bit consume;
    if (r) begin
      mReady  = 1'b1;
      mPrev   = 1'b1;
      mTick   = 1'b0;
      mMode   = M_IDLE;
      mSub    = 0;
      mSecs   = 0;
      mRoll   = 1'b0;
      mFreeze = 1'b0;
      mLatch  = 0;
    end else begin
      consume = (mMode == M_RUN) && mTick && !c && !p;
`ifdef STOPWATCH_LAP_EN
      if (c) begin
        mFreeze = 1'b0;
      end else if (l && mMode == M_RUN) begin
        if (!mFreeze) mLatch = mSecs;
        mFreeze = !mFreeze;
      end
`else
      if (l) mFreeze = 1'b0;
`endif
      mRoll = 1'b0;
      if (c) begin
        mSub  = 0;
        mSecs = 0;
      end else if (consume) begin
        mSub++;
        if (mSub == TPS) begin
          mSub = 0;
          mSecs++;
          if (mSecs == 3600) begin
            mSecs = 0;
            mRoll = 1'b1;
          end
        end
      end
      if (c) mMode = M_IDLE;
      else if (mMode == M_RUN && p) mMode = M_PAUSE;
      else if (mMode != M_RUN && s) mMode = M_RUN;
      mTick = d && !mPrev;
      mPrev = d;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, and queue the expected
  // response for the monitor.
  task automatic applyStimulus(input bit r, input bit s, input bit p,
                               input bit c, input bit l);
    exp_t e;
    rst = r;
    divided_clk = dLvl;
    start = s;
    stop = p;
    clear = c;
    lap = l;
    @(posedge clk_in);
    stepModel(r, dLvl, s, p, c, l);
    if (mReady) begin
      e.tick     = mTick;
      e.running  = (mMode == M_RUN);
      e.digits   = toDigits(mFreeze ? mLatch : mSecs);
      e.rollover = mRoll;
      expQ.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tickRise();
    dLvl = 1'b0;
    idle(1);
    dLvl = 1'b1;
    idle(1);
  endtask

  task automatic runSeconds(input int n);
    repeat (n * TPS) tickRise();
    idle(2);
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("tick", {15'd0, tick}, {15'd0, e.tick});
    checkField("running", {15'd0, running}, {15'd0, e.running});
    checkField("digits", dutDigits(), e.digits);
    checkField("rollover", {15'd0, rollover}, {15'd0, e.rollover});
  endtask

  // Monitor: every cycle after reset the DUT presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rollover === 1'b1) rollCount++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    $display("[TB] tick_stopwatch bench, TICKS_PER_SEC=%0d", TPS);

    dLvl = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkField("reset_digits", dutDigits(), 16'h0000);
    checkField("reset_running", {15'd0, running}, 16'd0);

    // Start, four rising edges -> two seconds.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tickRise();
    idle(2);
    checkField("four_ticks_sec_ones", {12'd0, sec_ones}, 16'd2);

    // Stop coincident with a tick discards it; restart counts one more second.
    dLvl = 1'b0;
    idle(1);
    dLvl = 1'b1;
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    checkField("stop_tick_digits", dutDigits(), 16'h0002);
    checkField("stop_running", {15'd0, running}, 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runSeconds(1);
    checkField("restart_digits", dutDigits(), 16'h0003);
    checkField("restart_running", {15'd0, running}, 16'd1);

    // Clear with stop and start together at 00:37.
    runSeconds(34);
    checkField("at_0037", dutDigits(), 16'h0037);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkField("clear_digits", dutDigits(), 16'h0000);
    checkField("clear_running", {15'd0, running}, 16'd0);

    // Reset during RUN at 12:34 with a divided_clk edge in flight.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runSeconds(754);
    checkField("at_1234", dutDigits(), 16'h1234);
    dLvl = 1'b0;
    idle(1);
    dLvl = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkField("rst_digits", dutDigits(), 16'h0000);
    checkField("rst_tick", {15'd0, tick}, 16'd0);
    idle(1);
    checkField("post_rst_tick", {15'd0, tick}, 16'd0);

    // Count up to 59:59 and wrap once.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runSeconds(3599);
    checkField("at_5959", dutDigits(), 16'h5959);
    rollCount = 0;
    runSeconds(1);
    checkField("wrap_digits", dutDigits(), 16'h0000);
    checkField("rollover_pulses", 16'(rollCount), 16'd1);

`ifdef STOPWATCH_LAP_EN
    // Freeze display at 00:05, keep counting, release at 00:11.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runSeconds(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    runSeconds(6);
    checkField("lap_frozen", dutDigits(), 16'h0005);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkField("lap_released", dutDigits(), 16'h0011);
`endif

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      dLvl = 1'($urandom_range(0, 1));
      applyStimulus(($urandom_range(0, 255) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 9) == 0));
    end
    idle(2);

    repeat (2) @(negedge clk_in);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
